mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter MUL_LAT, default 1, giving the number of settle cycles allowed for the shared multiplier (1..7).
REQ-003 The block SHALL have parameter SAT_EN, default 0; when 1, the result is saturated on overflow.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: level request per requester, held until its done pulse.
REQ-007 The block SHALL have port a_in, input, 16*N_REQ bits: packed first operands; slice i is [16*i+15:16*i]; Q format is scale [15:13], signed mantissa [12:0].
REQ-008 The block SHALL have port b_in, input, 16*N_REQ bits: packed second operands, same packing and format as a_in.
REQ-009 The block SHALL have port gnt, output, N_REQ bits: registered one-hot grant, held for the whole operation.
REQ-010 The block SHALL have port done, output, N_REQ bits: one-hot, one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port result, output, 16 bits: registered product, valid while done is nonzero and held until the next completion.
REQ-012 The block SHALL have port ovf, output, 1 bit: registered overflow of the last product, updated together with result.
REQ-013 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-014 The block SHALL have port ovf_cnt, output, 8 bits: saturating count of overflowed products.
REQ-015 The block SHALL have ports mul_a and mul_b, output, 16 bits each: registered operands to the shared multiplier.
REQ-016 The block SHALL have port mul_en, output, 1 bit: multiplier enable, high only in BUSY.
REQ-017 The block SHALL have ports mul_out, input, 16 bits, and mul_ovf, input, 1 bit: the multiplier's product and overflow.

Function
REQ-018 The FSM SHALL have three states, IDLE, BUSY and DONE, with the following transitions:
- IDLE to BUSY when |req;
- BUSY to DONE when the settle counter reaches 0;
- DONE to IDLE unconditionally.
REQ-019 In IDLE with any req set, the block SHALL select the first requester with req high, searching upward from rr_ptr modulo N_REQ.
REQ-020 On the IDLE-to-BUSY edge, the block SHALL:
- set gnt to the one-hot index of the selected requester;
- latch that requester's a_in and b_in slices into mul_a and mul_b;
- load the settle counter with MUL_LAT-1.
REQ-021 In BUSY, the counter SHALL decrement by 1 per cycle, so BUSY lasts exactly MUL_LAT cycles.
REQ-022 On the BUSY-to-DONE edge, the block SHALL capture mul_out into result and mul_ovf into ovf, and increment ovf_cnt if mul_ovf is high and ovf_cnt is below 255.
REQ-023 With SAT_EN=1 and mul_ovf=1, result SHALL be:
- bits [15:13] taken from mul_out[15:13];
- bits [12:0] set to 13'h0FFF if mul_a[12] equals mul_b[12], otherwise 13'h1000.
REQ-024 In DONE, done SHALL equal gnt for exactly one cycle.
REQ-025 On the DONE-to-IDLE edge, the block SHALL clear gnt and set rr_ptr to (granted index + 1) mod N_REQ.
REQ-026 Latency SHALL be fixed:
- req sampled in IDLE cycle t;
- gnt high from cycle t+1;
- done in cycle t+1+MUL_LAT;
- next grant no earlier than cycle t+3+MUL_LAT.
REQ-027 Deassertion of req by the granted requester mid-operation SHALL NOT abort the operation; done still pulses.
REQ-028 Changes on a_in and b_in after the grant SHALL NOT affect mul_a, mul_b or result.
REQ-029 req changes during BUSY or DONE SHALL be ignored until the next IDLE cycle.
REQ-030 mul_a and mul_b SHALL hold their values outside BUSY.
REQ-031 ovf_cnt SHALL hold at 255 once reached.
REQ-032 The wrap of rr_ptr from N_REQ-1 to 0 SHALL be seamless.

Reset
REQ-033 While rst_n is low, the block SHALL immediately force:
- state to IDLE;
- gnt=0, done=0, result=0, ovf=0, busy=0, ovf_cnt=0, rr_ptr=0;
- mul_a=0, mul_b=0, mul_en=0;
- settle counter to 0.
REQ-034 Reset asserted mid-operation SHALL abort it with no done pulse; after release, pending requests SHALL be re-arbitrated from rr_ptr=0.

Verification
REQ-035 Single request (MUL_LAT=1): req=0001, a0=16'h0010, b0=16'h0020, model product 16'h0200 -> gnt=0001 in cycle 1, done=0001 in cycle 2 with result=16'h0200 and ovf=0, busy low in cycle 3.
REQ-036 Round robin (N_REQ=4): req=1111 held continuously -> grant order 0,1,2,3,0 with 3-cycle spacing and no requester starved.
REQ-037 Overflow with saturation (SAT_EN=1): a=16'h0FFF, b=16'h0FFF, mul_ovf=1, mul_out[15:13]=0 -> result=16'h0FFF, ovf=1, ovf_cnt increments by 1; repeating 300 times -> ovf_cnt=255.
REQ-038 Mid-operation reset: assert rst_n low during BUSY -> all outputs zero with no done pulse; after release with req=0100, the grant goes to requester 2.
REQ-039 Operand stability: change a_in and b_in and drop req one cycle after the grant -> result reflects the original operands and done still pulses.
REQ-040 MUL_LAT=3: single request -> BUSY for exactly 3 cycles and done in cycle 4.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// Bundle of the request/grant bus and the shared-multiplier hookup for
// mult_arbiter. The arbiter sits on the slave side. The requesters and the
// external multiplier sit on the master side.
interface mult_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] a_in;
  logic [16*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [15:0]         result;
  logic                ovf;
  logic                busy;
  logic [7:0]          ovf_cnt;
  logic [15:0]         mul_a;
  logic [15:0]         mul_b;
  logic                mul_en;
  logic [15:0]         mul_out;
  logic                mul_ovf;

  modport slave (
    input  req, a_in, b_in, mul_out, mul_ovf,
    output gnt, done, result, ovf, busy, ovf_cnt, mul_a, mul_b, mul_en
  );

  modport master (
    output req, a_in, b_in, mul_out, mul_ovf,
    input  gnt, done, result, ovf, busy, ovf_cnt, mul_a, mul_b, mul_en
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that gives N_REQ requesters access to one shared
// multiplier. The winner's operands are latched, and the block waits MUL_LAT
// settle cycles. It then captures the product (optionally saturated on
// overflow) and pulses done back to the winner.
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1,
  parameter int SAT_EN  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 1);
  localparam logic [N_REQ-1:0] ONE_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic [PTR_W-1:0]  gnt_idx_r;
  logic [2:0]        cnt_r;
  logic [N_REQ-1:0]  gnt_r;
  logic [N_REQ-1:0]  done_r;
  logic [15:0]       result_r;
  logic              ovf_r;
  logic              busy_r;
  logic [7:0]        ovf_cnt_r;
  logic [15:0]       mul_a_r;
  logic [15:0]       mul_b_r;
  logic              mul_en_r;

  logic              pick_found_s;
  logic [PTR_W-1:0]  pick_idx_s;

  // Index (base + step) modulo N_REQ; both arguments are below N_REQ.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                 input int step);
    int sum_v;
    sum_v = int'(base) + step;
    sum_v = (sum_v >= N_REQ) ? (sum_v - N_REQ) : sum_v;
    return sum_v[PTR_W-1:0];
  endfunction

  // Clamp an overflowed product to the largest magnitude with the sign
  // implied by the operand sign bits. The scale field passes through.
  function automatic logic [15:0] sat_fix(input logic [15:0] prod,
                                          input logic       ovf_in,
                                          input logic       sign_a,
                                          input logic       sign_b);
    logic [15:0] res_v;
    if ((SAT_EN != 0) && ovf_in) begin
      res_v = {prod[15:13], (sign_a == sign_b) ? 13'h0FFF : 13'h1000};
    end else begin
      res_v = prod;
    end
    return res_v;
  endfunction

  // Round-robin pick: first active request at or above rr_ptr, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found_s && bus.req[wrap_idx(rr_ptr_r, k)]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = wrap_idx(rr_ptr_r, k);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Control FSM with every output registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= '0;
      gnt_idx_r <= '0;
      cnt_r     <= 3'd0;
      gnt_r     <= '0;
      done_r    <= '0;
      result_r  <= 16'h0000;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      ovf_cnt_r <= 8'd0;
      mul_a_r   <= 16'h0000;
      mul_b_r   <= 16'h0000;
      mul_en_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            state_r   <= ST_BUSY;
            gnt_idx_r <= pick_idx_s;
            gnt_r     <= ONE_LSB << pick_idx_s;
            mul_a_r   <= bus.a_in[{pick_idx_s, 4'b0000} +: 16];
            mul_b_r   <= bus.b_in[{pick_idx_s, 4'b0000} +: 16];
            cnt_r     <= CNT_LOAD;
            busy_r    <= 1'b1;
            mul_en_r  <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r == 3'd0) begin
            state_r  <= ST_DONE;
            result_r <= sat_fix(bus.mul_out, bus.mul_ovf, mul_a_r[12], mul_b_r[12]);
            ovf_r    <= bus.mul_ovf;
            done_r   <= gnt_r;
            mul_en_r <= 1'b0;
            if (bus.mul_ovf && (ovf_cnt_r != 8'hFF)) begin
              ovf_cnt_r <= ovf_cnt_r + 8'd1;
            end else begin
              ovf_cnt_r <= ovf_cnt_r;
            end
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          done_r   <= '0;
          gnt_r    <= '0;
          busy_r   <= 1'b0;
          rr_ptr_r <= wrap_idx(gnt_idx_r, 1);
        end
        default: begin
          state_r  <= ST_IDLE;
          done_r   <= '0;
          gnt_r    <= '0;
          busy_r   <= 1'b0;
          mul_en_r <= 1'b0;
          cnt_r    <= 3'd0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.done    = done_r;
  assign bus.result  = result_r;
  assign bus.ovf     = ovf_r;
  assign bus.busy    = busy_r;
  assign bus.ovf_cnt = ovf_cnt_r;
  assign bus.mul_a   = mul_a_r;
  assign bus.mul_b   = mul_b_r;
  assign bus.mul_en  = mul_en_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter. The main instance uses MUL_LAT=1 with saturation
// enabled, and a second instance uses MUL_LAT=3 without saturation. Each
// shared multiplier is modelled as a plain 16x16 product. Overflow means that
// any upper product bit is set. An override can force mul_out and mul_ovf.
module tb_mult_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_arbiter_if #(.N_REQ(NR)) bus_s ();
  mult_arbiter_if #(.N_REQ(NR)) bus_l ();

  mult_arbiter #(.N_REQ(NR), .MUL_LAT(1), .SAT_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );
  mult_arbiter #(.N_REQ(NR), .MUL_LAT(3), .SAT_EN(0)) u_lat (
    .clk(clk), .rst_n(rst_n), .bus(bus_l)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic        ovr_en;
  logic [15:0] ovr_out;
  logic        ovr_ovf;
  logic [31:0] prod_s, prod_l;

  // Multiplier model for the main instance, with an optional override.
  always_comb begin
    prod_s = 32'(bus_s.mul_a) * 32'(bus_s.mul_b);
    bus_s.mul_out = ovr_en ? ovr_out : prod_s[15:0];
    bus_s.mul_ovf = ovr_en ? ovr_ovf : (prod_s[31:16] != 16'h0000);
  end

  // Multiplier model for the long-latency instance.
  always_comb begin
    prod_l = 32'(bus_l.mul_a) * 32'(bus_l.mul_b);
    bus_l.mul_out = prod_l[15:0];
    bus_l.mul_ovf = (prod_l[31:16] != 16'h0000);
  end

  int          rr_model;
  int          cnt_model;
  int          w;
  logic [3:0]  mask;
  logic [63:0] av, bv;
  logic [15:0] ea, eb, er;
  logic        eo;
  logic [3:0]  eg;

  // Reference result: {overflow, result}, taken from the operands themselves.
  function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input bit sat);
    logic [31:0] p;
    logic        o;
    logic [15:0] r;
    p = 32'(a) * 32'(b);
    o = (p[31:16] != 16'h0000);
    r = p[15:0];
    if (sat && o) r = {p[15:13], (a[12] == b[12]) ? 13'h0FFF : 13'h1000};
    return {o, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ovr_en = 1'b0; ovr_out = 16'h0000; ovr_ovf = 1'b0;
    bus_s.req = '0; bus_s.a_in = '0; bus_s.b_in = '0;
    bus_l.req = '0; bus_l.a_in = '0; bus_l.b_in = '0;
    #2;
    n_total++;
    if ({bus_s.gnt, bus_s.done, bus_s.result, bus_s.ovf, bus_s.busy, bus_s.ovf_cnt,
         bus_s.mul_a, bus_s.mul_b, bus_s.mul_en} !== '0)
      $display("FAIL reset_main: outputs not all zero (gnt=%b res=%h busy=%b)", bus_s.gnt, bus_s.result, bus_s.busy);
    else n_pass++;
    n_total++;
    if ({bus_l.gnt, bus_l.done, bus_l.result, bus_l.ovf, bus_l.busy, bus_l.ovf_cnt,
         bus_l.mul_a, bus_l.mul_b, bus_l.mul_en} !== '0)
      $display("FAIL reset_lat: outputs not all zero (gnt=%b res=%h busy=%b)", bus_l.gnt, bus_l.result, bus_l.busy);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_total++;
    if (bus_s.busy !== 1'b0) $display("FAIL idle_no_req: busy=%b want 0", bus_s.busy);
    else n_pass++;
    rr_model = 0; cnt_model = 0;
  endtask

  task automatic test_single();
    bus_s.a_in[15:0] = 16'h0010; bus_s.b_in[15:0] = 16'h0020; bus_s.req = 4'b0001;
    tick();
    n_total++;
    if ({bus_s.gnt, bus_s.busy, bus_s.mul_en, bus_s.done} !== {4'b0001, 1'b1, 1'b1, 4'b0000})
      $display("FAIL single_grant: gnt=%b busy=%b en=%b done=%b want 0001 1 1 0000", bus_s.gnt, bus_s.busy, bus_s.mul_en, bus_s.done);
    else n_pass++;
    tick();
    n_total++;
    if ({bus_s.done, bus_s.result, bus_s.ovf} !== {4'b0001, 16'h0200, 1'b0})
      $display("FAIL single_done: done=%b res=%h ovf=%b want 0001 0200 0", bus_s.done, bus_s.result, bus_s.ovf);
    else n_pass++;
    bus_s.req = 4'b0000;
    tick();
    n_total++;
    if ({bus_s.busy, bus_s.gnt, bus_s.done} !== 9'b0)
      $display("FAIL single_idle: busy=%b gnt=%b done=%b want all 0", bus_s.busy, bus_s.gnt, bus_s.done);
    else n_pass++;
    rr_model = 1;
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    rr_model = 0; cnt_model = 0;
    av = {$urandom(), $urandom()}; bv = {$urandom(), $urandom()};
    bus_s.a_in = av; bus_s.b_in = bv; bus_s.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'(1 << (k % 4));
      {eo, er} = ref_op(av[16*(k%4) +: 16], bv[16*(k%4) +: 16], 1'b1);
      if (eo && cnt_model < 255) cnt_model++;
      tick();
      n_total++;
      if (bus_s.gnt !== eg) $display("FAIL rr_grant%0d: gnt=%b want %b", k, bus_s.gnt, eg);
      else n_pass++;
      tick();
      n_total++;
      if ({bus_s.done, bus_s.result, bus_s.ovf} !== {eg, er, eo})
        $display("FAIL rr_done%0d: done=%b res=%h ovf=%b want %b %h %b", k, bus_s.done, bus_s.result, bus_s.ovf, eg, er, eo);
      else n_pass++;
      tick();
      if (k == 4) bus_s.req = 4'b0000;
      n_total++;
      if ({bus_s.busy, bus_s.gnt} !== 5'b0) $display("FAIL rr_gap%0d: busy=%b gnt=%b want 0", k, bus_s.busy, bus_s.gnt);
      else n_pass++;
    end
    rr_model = 1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      mask = 4'($urandom_range(1, 15));
      av = {$urandom(), $urandom()}; bv = {$urandom(), $urandom()};
      bus_s.req = mask; bus_s.a_in = av; bus_s.b_in = bv;
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && mask[(rr_model + k) % NR]) w = (rr_model + k) % NR;
      ea = av[16*w +: 16]; eb = bv[16*w +: 16];
      eg = 4'(1 << w);
      {eo, er} = ref_op(ea, eb, 1'b1);
      if (eo && cnt_model < 255) cnt_model++;
      tick();
      n_total++;
      if ({bus_s.gnt, bus_s.mul_a, bus_s.mul_b} !== {eg, ea, eb})
        $display("FAIL rand%0d_grant: gnt=%b a=%h b=%h want %b %h %h", r, bus_s.gnt, bus_s.mul_a, bus_s.mul_b, eg, ea, eb);
      else n_pass++;
      bus_s.req = 4'($urandom());
      bus_s.a_in = {$urandom(), $urandom()}; bus_s.b_in = {$urandom(), $urandom()};
      tick();
      n_total++;
      if ({bus_s.done, bus_s.result, bus_s.ovf, bus_s.ovf_cnt} !== {eg, er, eo, 8'(cnt_model)})
        $display("FAIL rand%0d_done: done=%b res=%h ovf=%b cnt=%0d want %b %h %b %0d", r, bus_s.done, bus_s.result, bus_s.ovf, bus_s.ovf_cnt, eg, er, eo, cnt_model);
      else n_pass++;
      bus_s.req = 4'b0000;
      tick();
      n_total++;
      if ({bus_s.busy, bus_s.gnt} !== 5'b0) $display("FAIL rand%0d_idle: busy=%b gnt=%b want 0", r, bus_s.busy, bus_s.gnt);
      else n_pass++;
      rr_model = (w + 1) % NR;
    end
  endtask

  task automatic test_operand_stability();
    bus_s.a_in[63:48] = 16'h0123; bus_s.b_in[63:48] = 16'h0011; bus_s.req = 4'b1000;
    tick();
    n_total++;
    if ({bus_s.gnt, bus_s.mul_a} !== {4'b1000, 16'h0123}) $display("FAIL stab_grant: gnt=%b a=%h want 1000 0123", bus_s.gnt, bus_s.mul_a);
    else n_pass++;
    bus_s.a_in = {$urandom(), $urandom()}; bus_s.b_in = {$urandom(), $urandom()}; bus_s.req = 4'b0000;
    tick();
    n_total++;
    if ({bus_s.done, bus_s.result, bus_s.ovf, bus_s.mul_a, bus_s.mul_b} !== {4'b1000, 16'h1353, 1'b0, 16'h0123, 16'h0011})
      $display("FAIL stab_done: done=%b res=%h ovf=%b a=%h b=%h want 1000 1353 0 0123 0011", bus_s.done, bus_s.result, bus_s.ovf, bus_s.mul_a, bus_s.mul_b);
    else n_pass++;
    tick();
    rr_model = 0;
  endtask

  task automatic test_mid_reset();
    bus_s.a_in[31:16] = 16'h0002; bus_s.b_in[31:16] = 16'h0003; bus_s.req = 4'b0010;
    tick();
    n_total++;
    if ({bus_s.gnt, bus_s.busy} !== {4'b0010, 1'b1}) $display("FAIL mid_grant: gnt=%b busy=%b want 0010 1", bus_s.gnt, bus_s.busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus_s.gnt, bus_s.done, bus_s.result, bus_s.ovf, bus_s.busy, bus_s.ovf_cnt,
         bus_s.mul_a, bus_s.mul_b, bus_s.mul_en} !== '0)
      $display("FAIL mid_reset_zero: gnt=%b res=%h busy=%b cnt=%0d want all 0", bus_s.gnt, bus_s.result, bus_s.busy, bus_s.ovf_cnt);
    else n_pass++;
    tick();
    n_total++;
    if (bus_s.done !== 4'b0000) $display("FAIL mid_no_done: done=%b want 0000", bus_s.done);
    else n_pass++;
    cnt_model = 0;
    bus_s.a_in[47:32] = 16'h0004; bus_s.b_in[47:32] = 16'h0005; bus_s.req = 4'b0100;
    rst_n = 1'b1;
    tick();
    n_total++;
    if (bus_s.gnt !== 4'b0100) $display("FAIL mid_regrant: gnt=%b want 0100", bus_s.gnt);
    else n_pass++;
    tick();
    n_total++;
    if ({bus_s.done, bus_s.result} !== {4'b0100, 16'h0014}) $display("FAIL mid_done: done=%b res=%h want 0100 0014", bus_s.done, bus_s.result);
    else n_pass++;
    bus_s.req = 4'b0000;
    tick();
    rr_model = 3;
  endtask

  task automatic test_mul_lat3();
    bus_l.a_in[31:16] = 16'h0003; bus_l.b_in[31:16] = 16'h0005; bus_l.req = 4'b0010;
    tick();
    n_total++;
    if ({bus_l.gnt, bus_l.busy, bus_l.mul_en} !== {4'b0010, 1'b1, 1'b1})
      $display("FAIL lat_grant: gnt=%b busy=%b en=%b want 0010 1 1", bus_l.gnt, bus_l.busy, bus_l.mul_en);
    else n_pass++;
    for (int c = 2; c <= 3; c++) begin
      tick();
      n_total++;
      if ({bus_l.done, bus_l.mul_en, bus_l.busy} !== {4'b0000, 1'b1, 1'b1})
        $display("FAIL lat_busy_c%0d: done=%b en=%b busy=%b want 0000 1 1", c, bus_l.done, bus_l.mul_en, bus_l.busy);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({bus_l.done, bus_l.result, bus_l.mul_en} !== {4'b0010, 16'h000F, 1'b0})
      $display("FAIL lat_done: done=%b res=%h en=%b want 0010 000f 0", bus_l.done, bus_l.result, bus_l.mul_en);
    else n_pass++;
    bus_l.req = 4'b0000;
    tick();
    n_total++;
    if ({bus_l.busy, bus_l.gnt} !== 5'b0) $display("FAIL lat_idle: busy=%b gnt=%b want 0", bus_l.busy, bus_l.gnt);
    else n_pass++;
    bus_l.a_in[15:0] = 16'h4001; bus_l.b_in[15:0] = 16'h0011; bus_l.req = 4'b0001;
    tick();
    bus_l.req = 4'b0000;
    tick(); tick(); tick();
    n_total++;
    if ({bus_l.done, bus_l.result, bus_l.ovf, bus_l.ovf_cnt} !== {4'b0001, 16'h4011, 1'b1, 8'd1})
      $display("FAIL lat_nosat: done=%b res=%h ovf=%b cnt=%0d want 0001 4011 1 1", bus_l.done, bus_l.result, bus_l.ovf, bus_l.ovf_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic run_plain(input logic [15:0] a, input logic [15:0] b);
    bus_s.a_in[15:0] = a; bus_s.b_in[15:0] = b; bus_s.req = 4'b0001;
    tick(); tick();
    bus_s.req = 4'b0000;
    tick();
  endtask

  task automatic test_overflow();
    ovr_en = 1'b1; ovr_out = 16'h0000; ovr_ovf = 1'b1;
    bus_s.a_in[15:0] = 16'h0FFF; bus_s.b_in[15:0] = 16'h0FFF; bus_s.req = 4'b0001;
    tick(); tick();
    n_total++;
    if ({bus_s.result, bus_s.ovf, bus_s.ovf_cnt} !== {16'h0FFF, 1'b1, 8'(cnt_model + 1)})
      $display("FAIL ovf_sat_pos: res=%h ovf=%b cnt=%0d want 0fff 1 %0d", bus_s.result, bus_s.ovf, bus_s.ovf_cnt, cnt_model + 1);
    else n_pass++;
    bus_s.req = 4'b0000;
    tick();
    ovr_out = 16'hA000;
    bus_s.a_in[15:0] = 16'h1000; bus_s.b_in[15:0] = 16'h0FFF; bus_s.req = 4'b0001;
    tick(); tick();
    n_total++;
    if ({bus_s.result, bus_s.ovf, bus_s.ovf_cnt} !== {16'hB000, 1'b1, 8'(cnt_model + 2)})
      $display("FAIL ovf_sat_neg: res=%h ovf=%b cnt=%0d want b000 1 %0d", bus_s.result, bus_s.ovf, bus_s.ovf_cnt, cnt_model + 2);
    else n_pass++;
    bus_s.req = 4'b0000;
    tick();
    ovr_out = 16'h0000;
    for (int i = 0; i < 298; i++) run_plain(16'h0FFF, 16'h0FFF);
    n_total++;
    if (bus_s.ovf_cnt !== 8'd255) $display("FAIL ovf_cnt_sat: cnt=%0d want 255", bus_s.ovf_cnt);
    else n_pass++;
    ovr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_operand_stability();
    test_mid_reset();
    test_mul_lat3();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
